// File: rtl/adc_serial_reader_if.sv
// rtl/adc_serial_reader_if.sv - pin and result bundle for the serial ADC read master
//
// Purpose: groups the ADC pins and the parallel result handshake for adc_serial_reader.
// Signals:
//   START     conversion request (may be asynchronous to CLK)
//   SDATA_ADC serial data from ADC
//   CS_ADC_N  ADC chip select, active low
//   SCLK_ADC  ADC serial clock, idles high
//   DATA      last conversion result (DATA_BITS wide)
//   VALID     one-CLK pulse, DATA updated
//   BUSY      request accepted until end of quiet time
//   ERR       leading-zero violation flag (only with ADC_LEADZERO_CHECK_EN)
// Modports: master = reader side, slave = ADC/acquisition side.
interface adc_serial_reader_if #(
  parameter int DATA_BITS = 12
);
  logic                 START;
  logic                 SDATA_ADC;
  logic                 CS_ADC_N;
  logic                 SCLK_ADC;
  logic [DATA_BITS-1:0] DATA;
  logic                 VALID;
  logic                 BUSY;
`ifdef ADC_LEADZERO_CHECK_EN
  logic                 ERR;

  modport master (
    input  START, SDATA_ADC,
    output CS_ADC_N, SCLK_ADC, DATA, VALID, BUSY, ERR
  );
  modport slave (
    output START, SDATA_ADC,
    input  CS_ADC_N, SCLK_ADC, DATA, VALID, BUSY, ERR
  );
`else
  modport master (
    input  START, SDATA_ADC,
    output CS_ADC_N, SCLK_ADC, DATA, VALID, BUSY
  );
  modport slave (
    output START, SDATA_ADC,
    input  CS_ADC_N, SCLK_ADC, DATA, VALID, BUSY
  );
`endif
endinterface

// File: rtl/adc_serial_reader.sv
// rtl/adc_serial_reader.sv - SPI-style read master for a single-channel serial ADC
//
// Purpose: on a START rising edge runs one FRAME_BITS-clock frame, captures the
// trailing DATA_BITS bits, presents them on DATA with a one-cycle VALID, then holds
// CS_ADC_N high for QUIET_CYCLES before accepting another request.
// Ports:
//   CLK   system clock
//   RESET asynchronous, active-high reset
//   bus   adc_serial_reader_if.master (START, SDATA_ADC in; CS_ADC_N, SCLK_ADC,
//         DATA, VALID, BUSY out; ERR out when ADC_LEADZERO_CHECK_EN is defined)
// Optional: define ADC_LEADZERO_CHECK_EN to add ERR, set when any leading bit of
// the frame (above DATA_BITS) is 1.
module adc_serial_reader #(
  parameter int FRAME_BITS   = 16,
  parameter int DATA_BITS    = 12,
  parameter int CLK_DIV      = 3,
  parameter int QUIET_CYCLES = 8
) (
  input logic            CLK,
  input logic            RESET,
  adc_serial_reader_if.master bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_END   = 3'd3;
  localparam logic [2:0] ST_QUIET = 3'd4;

  localparam int CNT_MAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int BW      = $clog2(FRAME_BITS) + 1;
  // Without the check only the result bits are ever read, so the leading bits
  // simply fall off the top of a narrower register.
`ifdef ADC_LEADZERO_CHECK_EN
  localparam int SHIFT_W = FRAME_BITS;
`else
  localparam int SHIFT_W = DATA_BITS;
`endif

  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [SHIFT_W-1:0]   shift_reg;
  logic                 s1, s2, start_req;
  logic                 start_edge;
  logic                 cs_n, sclk, valid, busy;
  logic [DATA_BITS-1:0] data;
  logic                 div_done;
`ifdef ADC_LEADZERO_CHECK_EN
  logic                 err;
`endif

  assign start_edge = s1 & ~s2;
  assign div_done   = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      start_req <= 1'b0;
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      cs_n      <= 1'b1;
      sclk      <= 1'b1;
      valid     <= 1'b0;
      busy      <= 1'b0;
      data      <= '0;
`ifdef ADC_LEADZERO_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      s1        <= bus.START;
      s2        <= s1;
      // Registered edge puts acceptance two edges after the synchronizer first sees START.
      start_req <= start_edge;
      valid     <= 1'b0;
      case (state)
        ST_IDLE: begin
          cs_n <= 1'b1;
          sclk <= 1'b1;
          cnt  <= '0;
          if (start_req) begin
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (div_done) begin
            cnt   <= '0;
            sclk  <= 1'b0;
            state <= ST_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (div_done) begin
            cnt  <= '0;
            sclk <= ~sclk;
            if (!sclk) begin
              // Rising SCLK: ADC data has been stable since the preceding falling edge.
              shift_reg <= {shift_reg[SHIFT_W-2:0], bus.SDATA_ADC};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == BW'(FRAME_BITS - 1)) state <= ST_END;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_END: begin
          if (div_done) begin
            cnt   <= '0;
            cs_n  <= 1'b1;
            data  <= shift_reg[DATA_BITS-1:0];
            valid <= 1'b1;
`ifdef ADC_LEADZERO_CHECK_EN
            err   <= |shift_reg[FRAME_BITS-1:DATA_BITS];
`endif
            state <= ST_QUIET;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_QUIET: begin
          if (cnt == CW'(QUIET_CYCLES - 1)) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cs_n  <= 1'b1;
          sclk  <= 1'b1;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.CS_ADC_N = cs_n;
  assign bus.SCLK_ADC = sclk;
  assign bus.DATA     = data;
  assign bus.VALID    = valid;
  assign bus.BUSY     = busy;
`ifdef ADC_LEADZERO_CHECK_EN
  assign bus.ERR      = err;
`endif

endmodule

// File: tb/tb_adc_serial_reader.sv
// tb/tb_adc_serial_reader.sv - directed self-checking bench for adc_serial_reader
module tb_adc_serial_reader;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] adc_frame = 16'h0000;
  int   fall_idx = 0;

  adc_serial_reader_if #(.DATA_BITS(12)) bus ();

  adc_serial_reader dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // ADC model: frame MSB appears on the first SCLK falling edge, one bit per fall.
  always @(negedge bus.SCLK_ADC or negedge bus.CS_ADC_N) begin
    if (!bus.CS_ADC_N) begin
      if (bus.SCLK_ADC) begin
        fall_idx = 0;
      end else begin
        if (fall_idx < 16) bus.SDATA_ADC = adc_frame[15 - fall_idx];
        fall_idx++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [15:0] frame, input logic [11:0] exp, input bit repulse);
    int n, lows, rises, valids;
    logic prev_sclk;
    adc_frame = frame;
    @(negedge CLK);
    bus.START = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (bus.CS_ADC_N && n < 20);
    check("accept_latency", n, 3);
    check("busy_at_accept", {31'd0, bus.BUSY}, 1);
    lows = 1;
    rises = 0;
    prev_sclk = bus.SCLK_ADC;
    n = 0;
    while (!bus.VALID && n < 300) begin
      @(negedge CLK);
      n++;
      if (!bus.CS_ADC_N) lows++;
      if (bus.SCLK_ADC && !prev_sclk) rises++;
      prev_sclk = bus.SCLK_ADC;
      if (repulse && n == 40) bus.START = 1'b0;
      if (repulse && n == 50) bus.START = 1'b1;
    end
    check("valid_seen", {31'd0, bus.VALID}, 1);
    check("cs_high_at_valid", {31'd0, bus.CS_ADC_N}, 1);
    check("sclk_high_at_end", {31'd0, bus.SCLK_ADC}, 1);
    check("cs_low_cycles", lows, 99);
    check("sclk_rises", rises, 16);
    check("data", {20'd0, bus.DATA}, {20'd0, exp});
    bus.START = 1'b0;
    valids = 0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (bus.VALID) valids++;
      if (repulse && n == 3) bus.START = 1'b1;
    end while (bus.BUSY && n < 50);
    check("busy_quiet_cycles", n, 8);
    check("valid_one_cycle", valids, 0);
    lows = 0;
    repeat (30) begin
      @(negedge CLK);
      if (!bus.CS_ADC_N) lows++;
      if (bus.VALID) valids++;
    end
    check("no_extra_frame", lows, 0);
    check("no_extra_valid", valids, 0);
    check("data_hold", {20'd0, bus.DATA}, {20'd0, exp});
    bus.START = 1'b0;
  endtask

  initial begin
    int n, lows, valids, rises;
    logic prev_sclk;
    RESET = 1'b1;
    bus.START = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_cs", {31'd0, bus.CS_ADC_N}, 1);
    check("rst_sclk", {31'd0, bus.SCLK_ADC}, 1);
    check("rst_busy", {31'd0, bus.BUSY}, 0);
    check("rst_valid", {31'd0, bus.VALID}, 0);
    check("rst_data", {20'd0, bus.DATA}, 0);
`ifdef ADC_LEADZERO_CHECK_EN
    check("rst_err", {31'd0, bus.ERR}, 0);
`endif
    RESET = 1'b0;
    lows = 0;
    valids = 0;
    repeat (50) begin
      @(negedge CLK);
      if (!bus.CS_ADC_N || !bus.SCLK_ADC || bus.BUSY) lows++;
      if (bus.VALID) valids++;
    end
    check("idle_pins", lows, 0);
    check("idle_valid", valids, 0);
    check("idle_data", {20'd0, bus.DATA}, 0);

    run_frame(16'h0ABC, 12'hABC, 1'b0);
    run_frame(16'h0FFF, 12'hFFF, 1'b0);
    run_frame(16'h0001, 12'h001, 1'b0);
    run_frame(16'h0A5A, 12'hA5A, 1'b1);

    adc_frame = 16'h0555;
    @(negedge CLK);
    bus.START = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (bus.CS_ADC_N && n < 20);
    check("rst_frame_start", {31'd0, bus.CS_ADC_N}, 0);
    rises = 0;
    prev_sclk = bus.SCLK_ADC;
    n = 0;
    while (rises < 7 && n < 200) begin
      @(negedge CLK);
      n++;
      if (bus.SCLK_ADC && !prev_sclk) rises++;
      prev_sclk = bus.SCLK_ADC;
    end
    check("rst_reached_edge7", rises, 7);
    RESET = 1'b1;
    #1;
    check("midrst_cs", {31'd0, bus.CS_ADC_N}, 1);
    check("midrst_sclk", {31'd0, bus.SCLK_ADC}, 1);
    check("midrst_busy", {31'd0, bus.BUSY}, 0);
    check("midrst_valid", {31'd0, bus.VALID}, 0);
    bus.START = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    lows = 0;
    valids = 0;
    repeat (40) begin
      @(negedge CLK);
      if (!bus.CS_ADC_N) lows++;
      if (bus.VALID) valids++;
    end
    check("postrst_no_frame", lows, 0);
    check("postrst_no_valid", valids, 0);
    check("postrst_data", {20'd0, bus.DATA}, 0);
    run_frame(16'h0321, 12'h321, 1'b0);

`ifdef ADC_LEADZERO_CHECK_EN
    run_frame(16'h8ABC, 12'hABC, 1'b0);
    check("err_set", {31'd0, bus.ERR}, 1);
    run_frame(16'h0123, 12'h123, 1'b0);
    check("err_clear", {31'd0, bus.ERR}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
